// File: rtl/regfile_write_arbiter_if.sv
// Request/grant bundle shared by all writers of the register file.
// The writers drive requests, addresses and data; the arbiter returns the one-hot grant.
interface regfile_write_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 64,
  parameter int ADDRW = 5
);
  logic [NREQ-1:0]       req;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;

  modport master (
    output req,
    output req_addr,
    output req_data,
    input  gnt
  );

  modport slave (
    input  req,
    input  req_addr,
    input  req_data,
    output gnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the register file.
// The winning address and data are registered, then decoded into one-hot register enables.
// The top register (X31, the zero register) is granted and acknowledged, but it is never enabled.
module regfile_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int ADDRW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave bus,
  input  logic                  freeze,
  output logic [NREGS-1:0]      wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDRW-1:0] ZERO_REG = ADDRW'(NREGS - 1);
  localparam logic [PTRW-1:0]  LAST_REQ = PTRW'(NREQ - 1);

  logic [PTRW-1:0]  ptr;
  logic             valid_q;
  logic [ADDRW-1:0] addr_q;
  logic [WIDTH-1:0] data_q;

  logic [PTRW-1:0]  winner;
  logic             found;
  logic [NREQ-1:0]  gnt_c;
  logic             accept;
  logic [ADDRW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;
  int               idx;

  // Search for the first requester at or after ptr, wrapping around, and grant it unless frozen or in reset
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    gnt_c  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx[PTRW-1:0];
      end
    end
    if (found && !reset && !freeze) begin
      gnt_c[winner] = 1'b1;
    end
  end

  assign bus.gnt = gnt_c;
  assign accept  = |gnt_c;

  // Select the granted requester's address and data lanes
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        sel_addr = bus.req_addr[i*ADDRW +: ADDRW];
        sel_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage and pointer: capture the accepted write, advance past the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      addr_q  <= sel_addr;
      data_q  <= sel_data;
      ptr     <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // One-hot decode.
  // Reset masks a write that is still pending in the output stage, so a reset discards the write.
  always_comb begin
    wr_en = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (valid_q && !reset && (addr_q == k[ADDRW-1:0]) && (addr_q != ZERO_REG)) begin
        wr_en[k] = 1'b1;
      end
    end
  end

  assign wr_data = data_q;
  assign busy    = (|bus.req) || valid_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed checks of the register-file write arbiter, with hand-computed expectations.
module tb_regfile_write_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 64;
  localparam int NREGS = 32;
  localparam int ADDRW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             freeze;
  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .ADDRW(ADDRW)) bus ();

  regfile_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREGS(NREGS), .ADDRW(ADDRW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .freeze  (freeze),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [ADDRW-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_addr[i*ADDRW +: ADDRW] = a;
    bus.req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Inputs change 1 time unit after the rising edge.
  // The checks then sample at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] dpat(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  initial begin
    reset    = 1'b1;
    freeze   = 1'b0;
    bus.req  = 3'b111;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) set_lane(i, ADDRW'(i + 1), dpat(i));

    // Reset held for two cycles while all requesters are asking
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_wr_en", 64'(wr_en), 64'h0);
      chk("rst_wr_data", wr_data, 64'h0);
      chk("rst_busy", 64'(busy), 64'h1);
      next_cycle();
    end
    reset = 1'b0;

    // Round robin with all requests held: grants 0,1,2,0,1,2, and the writes follow one cycle behind
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_gnt", 64'(bus.gnt), 64'(1 << (j % 3)));
      if (j == 0) chk("rr_wr_en0", 64'(wr_en), 64'h0);
      else begin
        chk("rr_wr_en", 64'(wr_en), 64'(1 << (((j - 1) % 3) + 1)));
        chk("rr_wr_data", wr_data, dpat((j - 1) % 3));
      end
      next_cycle();
    end
    bus.req = 3'b000;
    @(negedge clk);
    chk("rr_tail_gnt", 64'(bus.gnt), 64'h0);
    chk("rr_tail_wr_en", 64'(wr_en), 64'h8);
    chk("rr_tail_busy", 64'(busy), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("idle_wr_en", 64'(wr_en), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);
    next_cycle();

    // Single write from requester 1 to register 5 (ptr is 0 here)
    bus.req = 3'b010;
    set_lane(1, 5'd5, 64'h0000010204080001);
    @(negedge clk);
    chk("single_gnt", 64'(bus.gnt), 64'h2);
    next_cycle();
    bus.req = 3'b000;
    @(negedge clk);
    chk("single_wr_en", 64'(wr_en), 64'h20);
    chk("single_wr_data", wr_data, 64'h0000010204080001);
    chk("single_busy", 64'(busy), 64'h1);
    next_cycle();
    @(negedge clk);
    chk("single_after_wr_en", 64'(wr_en), 64'h0);
    chk("single_after_busy", 64'(busy), 64'h0);
    next_cycle();

    // Write to the zero register from requester 2 (ptr is 2 here)
    bus.req = 3'b100;
    set_lane(2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("x31_gnt", 64'(bus.gnt), 64'h4);
    chk("x31_wr_en_pre", 64'(wr_en), 64'h0);
    next_cycle();
    bus.req = 3'b000;
    @(negedge clk);
    chk("x31_wr_en", 64'(wr_en), 64'h0);
    chk("x31_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x31_busy", 64'(busy), 64'h1);
    next_cycle();

    // After the zero-register write, ptr has wrapped to 0, so requesters 1 and 2 resolve to 1
    bus.req = 3'b110;
    set_lane(1, 5'd12, 64'h1212);
    set_lane(2, 5'd13, 64'h1313);
    @(negedge clk);
    chk("ptr_wrap_gnt", 64'(bus.gnt), 64'h2);
    next_cycle();

    // Freeze for three cycles with 0 and 1 pending.
    // The already-registered write to reg 12 still pulses once.
    bus.req = 3'b011;
    freeze  = 1'b1;
    set_lane(0, 5'd10, 64'h1010);
    set_lane(1, 5'd7, 64'h0707);
    @(negedge clk);
    chk("frz_gnt0", 64'(bus.gnt), 64'h0);
    chk("frz_wr_en0", 64'(wr_en), 64'h1000);
    chk("frz_wr_data0", wr_data, 64'h1212);
    next_cycle();
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk("frz_gnt", 64'(bus.gnt), 64'h0);
      chk("frz_wr_en", 64'(wr_en), 64'h0);
      chk("frz_busy", 64'(busy), 64'h1);
      next_cycle();
    end
    // Release: ptr is 2, so with 0 and 1 pending the grant goes to 0 in the same cycle
    freeze = 1'b0;
    @(negedge clk);
    chk("frz_release_gnt", 64'(bus.gnt), 64'h1);
    next_cycle();

    // Requester 1 is granted (addr 7); then a reset arrives while that write is in the output stage
    bus.req = 3'b010;
    @(negedge clk);
    chk("mid_gnt", 64'(bus.gnt), 64'h2);
    chk("mid_wr_en_prev", 64'(wr_en), 64'h400);
    next_cycle();
    reset   = 1'b1;
    bus.req = 3'b110;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
    chk("mid_rst_wr_en", 64'(wr_en), 64'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_after_gnt", 64'(bus.gnt), 64'h2);
    chk("mid_after_wr_en", 64'(wr_en), 64'h0);
    next_cycle();
    bus.req = 3'b000;
    @(negedge clk);
    chk("mid_after_write", 64'(wr_en), 64'h80);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
